// File: rtl/vga_sync_gen.sv
// VGA raster timing generator: pixel/line counters, delayed sync pulses,
// line/frame strobes and a wrapping frame counter on the 25 MHz pixel clock.
module vga_sync_gen #(
   parameter int   H_ACTIVE   = 640,
   parameter int   H_FP       = 16,
   parameter int   H_SYNC     = 96,
   parameter int   H_BP       = 48,
   parameter int   V_ACTIVE   = 480,
   parameter int   V_FP       = 10,
   parameter int   V_SYNC     = 2,
   parameter int   V_BP       = 33,
   parameter logic HS_POL     = 1'b0,
   parameter logic VS_POL     = 1'b0,
   parameter int   SYNC_DELAY = 1
) (
   input  logic       clk25,
   input  logic       Reset,
   input  logic       en,
   output logic [9:0] xpos,
   output logic [9:0] ypos,
   output logic       visible,
   output logic       hsync,
   output logic       vsync,
   output logic       line_start,
   output logic       frame_end,
   output logic [7:0] frame_count
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_total
      $fatal(1, "vga_sync_gen: H_TOTAL/V_TOTAL exceed the 10-bit counter range");
   end
   if (SYNC_DELAY < 1 || SYNC_DELAY > 4) begin : g_bad_delay
      $fatal(1, "vga_sync_gen: SYNC_DELAY must be 1..4");
   end

   localparam logic [9:0]  H_MAX    = 10'(H_TOTAL - 1);
   localparam logic [9:0]  V_MAX    = 10'(V_TOTAL - 1);
   localparam logic [10:0] H_ACT    = 11'(H_ACTIVE);
   localparam logic [10:0] V_ACT    = 11'(V_ACTIVE);
   localparam logic [10:0] HS_START = 11'(H_ACTIVE + H_FP);
   localparam logic [10:0] HS_END   = 11'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [10:0] VS_START = 11'(V_ACTIVE + V_FP);
   localparam logic [10:0] VS_END   = 11'(V_ACTIVE + V_FP + V_SYNC);

   logic [9:0]            x_r, y_r, x_next_s, y_next_s;
   logic [7:0]            fc_r, fc_next_s;
   logic                  hs_raw_s, vs_raw_s;
   logic [SYNC_DELAY-1:0] hs_pipe_r, vs_pipe_r;

   // Next raster position; the frame counter advances on the final pixel of the frame.
   always_comb begin
      x_next_s  = x_r;
      y_next_s  = y_r;
      fc_next_s = fc_r;
      if (x_r == H_MAX) begin
         x_next_s = 10'd0;
         if (y_r == V_MAX) begin
            y_next_s  = 10'd0;
            fc_next_s = fc_r + 8'd1;
         end else begin
            y_next_s  = y_r + 10'd1;
         end
      end else begin
         x_next_s = x_r + 10'd1;
      end
   end

   // Raw sync decode; vsync is evaluated per pixel so its edges fall at xpos == 0.
   always_comb begin
      hs_raw_s = ~HS_POL;
      vs_raw_s = ~VS_POL;
      if (({1'b0, x_r} >= HS_START) && ({1'b0, x_r} < HS_END)) begin
         hs_raw_s = HS_POL;
      end else begin
         hs_raw_s = ~HS_POL;
      end
      if (({1'b0, y_r} >= VS_START) && ({1'b0, y_r} < VS_END)) begin
         vs_raw_s = VS_POL;
      end else begin
         vs_raw_s = ~VS_POL;
      end
   end

   // Counter and sync-delay registers; everything freezes while en is low.
   always_ff @(posedge clk25 or negedge Reset) begin
      if (!Reset) begin
         x_r       <= 10'd0;
         y_r       <= 10'd0;
         fc_r      <= 8'd0;
         hs_pipe_r <= {SYNC_DELAY{~HS_POL}};
         vs_pipe_r <= {SYNC_DELAY{~VS_POL}};
      end else if (en) begin
         x_r          <= x_next_s;
         y_r          <= y_next_s;
         fc_r         <= fc_next_s;
         hs_pipe_r[0] <= hs_raw_s;
         vs_pipe_r[0] <= vs_raw_s;
         for (int i = 1; i < SYNC_DELAY; i++) begin
            hs_pipe_r[i] <= hs_pipe_r[i-1];
            vs_pipe_r[i] <= vs_pipe_r[i-1];
         end
      end
   end

   assign xpos        = x_r;
   assign ypos        = y_r;
   assign frame_count = fc_r;
   assign hsync       = hs_pipe_r[SYNC_DELAY-1];
   assign vsync       = vs_pipe_r[SYNC_DELAY-1];
   assign visible     = ({1'b0, x_r} < H_ACT) && ({1'b0, y_r} < V_ACT);
   assign line_start  = (x_r == 10'd0);
   assign frame_end   = (x_r == 10'd0) && ({1'b0, y_r} == V_ACT);

endmodule

// File: tb/tb_vga_sync_gen.sv
// Scoreboard bench for vga_sync_gen: three instances (default timing, default
// timing with SYNC_DELAY = 3, and a reduced raster for frame-level runs).
module tb_vga_sync_gen;

   typedef struct { int ha, hf, hs, hb, va, vf, vs, vb, dly; } cfg_t;
   typedef struct { int x, y, fc; logic [3:0] hp, vp; } mdl_t;
   typedef struct { int id; logic [32:0] exp; } sb_t;

   logic       clk25 = 1'b0;
   logic       rst_n = 1'b1;
   logic       en    = 1'b1;
   logic [9:0] xp [3];
   logic [9:0] yp [3];
   logic       vis [3];
   logic       hs [3];
   logic       vs [3];
   logic       ls [3];
   logic       fe [3];
   logic [7:0] fc [3];
   logic [32:0] obs [3];

   cfg_t cfg [3];
   mdl_t mdl [3];
   sb_t  sb_q [$];
   int   checks   = 0;
   int   failures = 0;

   int first_a, first_b, low_a, low_b;
   int fe_cnt, fe_at, ls_cnt, vs_low, vs_first, vs_last, fc0;

   always #20 clk25 = ~clk25;

   vga_sync_gen u_dut_a (
      .clk25(clk25), .Reset(rst_n), .en(en), .xpos(xp[0]), .ypos(yp[0]),
      .visible(vis[0]), .hsync(hs[0]), .vsync(vs[0]), .line_start(ls[0]),
      .frame_end(fe[0]), .frame_count(fc[0]));

   vga_sync_gen #(.SYNC_DELAY(3)) u_dut_b (
      .clk25(clk25), .Reset(rst_n), .en(en), .xpos(xp[1]), .ypos(yp[1]),
      .visible(vis[1]), .hsync(hs[1]), .vsync(vs[1]), .line_start(ls[1]),
      .frame_end(fe[1]), .frame_count(fc[1]));

   vga_sync_gen #(.H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
                  .V_ACTIVE(5), .V_FP(1), .V_SYNC(2), .V_BP(2),
                  .SYNC_DELAY(2)) u_dut_c (
      .clk25(clk25), .Reset(rst_n), .en(en), .xpos(xp[2]), .ypos(yp[2]),
      .visible(vis[2]), .hsync(hs[2]), .vsync(vs[2]), .line_start(ls[2]),
      .frame_end(fe[2]), .frame_count(fc[2]));

   always_comb begin
      for (int i = 0; i < 3; i++) begin
         obs[i] = {xp[i], yp[i], vis[i], hs[i], vs[i], ls[i], fe[i], fc[i]};
      end
   end

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic mdl_t m_reset();
      mdl_t m;
      m.x  = 0;
      m.y  = 0;
      m.fc = 0;
      m.hp = 4'hF;
      m.vp = 4'hF;
      return m;
   endfunction

   function automatic mdl_t m_step(input cfg_t c, input mdl_t m);
      mdl_t n;
      logic hs_on, vs_on;
      n = m;
      hs_on = (m.x >= c.ha + c.hf) && (m.x < c.ha + c.hf + c.hs);
      vs_on = (m.y >= c.va + c.vf) && (m.y < c.va + c.vf + c.vs);
      n.hp = {m.hp[2:0], ~hs_on};
      n.vp = {m.vp[2:0], ~vs_on};
      if (m.x == c.ha + c.hf + c.hs + c.hb - 1) begin
         n.x = 0;
         if (m.y == c.va + c.vf + c.vs + c.vb - 1) begin
            n.y  = 0;
            n.fc = (m.fc + 1) % 256;
         end else begin
            n.y = m.y + 1;
         end
      end else begin
         n.x = m.x + 1;
      end
      return n;
   endfunction

   function automatic logic [32:0] m_out(input cfg_t c, input mdl_t m);
      logic v, h, s, l, f;
      v = (m.x < c.ha) && (m.y < c.va);
      h = m.hp[c.dly-1];
      s = m.vp[c.dly-1];
      l = (m.x == 0);
      f = (m.x == 0) && (m.y == c.va);
      return {10'(m.x), 10'(m.y), v, h, s, l, f, 8'(m.fc)};
   endfunction

   task automatic push_expected();
      sb_t e;
      for (int i = 0; i < 3; i++) begin
         e.id  = i;
         e.exp = m_out(cfg[i], mdl[i]);
         sb_q.push_back(e);
      end
   endtask

   task automatic pop_compare();
      sb_t e;
      while (sb_q.size() > 0) begin
         e = sb_q.pop_front();
         check_val($sformatf("cycle_obs_%0d", e.id), obs[e.id], e.exp);
      end
   endtask

   task automatic tick(input logic en_v);
      en = en_v;
      @(posedge clk25);
      for (int i = 0; i < 3; i++) begin
         if (!rst_n) begin
            mdl[i] = m_reset();
         end else if (en_v) begin
            mdl[i] = m_step(cfg[i], mdl[i]);
         end
      end
      push_expected();
      @(negedge clk25);
      pop_compare();
   endtask

   initial begin
      cfg[0] = '{640, 16, 96, 48, 480, 10, 2, 33, 1};
      cfg[1] = '{640, 16, 96, 48, 480, 10, 2, 33, 3};
      cfg[2] = '{8, 2, 3, 3, 5, 1, 2, 2, 2};
      for (int i = 0; i < 3; i++) mdl[i] = m_reset();

      // reset hold
      #5 rst_n = 1'b0;
      @(negedge clk25);
      for (int k = 0; k < 3; k++) tick(1'b1);
      check_val("rst_xpos", xp[0], 10'd0);
      check_val("rst_ypos", yp[0], 10'd0);
      check_val("rst_hsync", hs[0], 1'b1);
      check_val("rst_vsync", vs[0], 1'b1);
      check_val("rst_frame_count", fc[0], 8'd0);
      check_val("rst_line_start", ls[0], 1'b1);

      // release, first line and hsync placement
      rst_n = 1'b1;
      first_a = -1; first_b = -1; low_a = 0; low_b = 0;
      for (int k = 1; k <= 800; k++) begin
         tick(1'b1);
         if (hs[0] == 1'b0) begin
            low_a++;
            if (first_a < 0) first_a = k;
         end
         if (hs[1] == 1'b0) begin
            low_b++;
            if (first_b < 0) first_b = k;
         end
      end
      check_val("x_after_800", xp[0], 10'd0);
      check_val("y_after_800", yp[0], 10'd1);
      check_val("hs_low_width_a", low_a, 96);
      check_val("hs_fall_a", first_a, 657);
      check_val("hs_low_width_b", low_b, 96);
      check_val("hs_fall_b", first_b, 659);

      // en dropped for 37 clocks at (123, 1)
      for (int k = 0; k < 123; k++) tick(1'b1);
      for (int k = 0; k < 37; k++) tick(1'b0);
      check_val("en_hold_x", xp[0], 10'd123);
      check_val("en_hold_y", yp[0], 10'd1);
      tick(1'b1);
      check_val("en_resume_x", xp[0], 10'd124);

      // one full reduced frame: strobes and vsync
      for (int n = 0; n < 200 && !(mdl[2].x == 0 && mdl[2].y == 0); n++) tick(1'b1);
      check_val("frame_align_c", {xp[2], yp[2]}, 20'd0);
      fc0 = int'(fc[2]);
      fe_cnt = 0; fe_at = -1; ls_cnt = 0; vs_low = 0; vs_first = -1; vs_last = -1;
      for (int k = 1; k <= 160; k++) begin
         tick(1'b1);
         if (fe[2]) begin
            fe_cnt++;
            fe_at = k;
         end
         if (ls[2]) ls_cnt++;
         if (!vs[2]) begin
            vs_low++;
            if (vs_first < 0) vs_first = k;
            vs_last = k;
         end
      end
      check_val("frame_end_count", fe_cnt, 1);
      check_val("frame_end_pos", fe_at, 80);
      check_val("line_start_count", ls_cnt, 10);
      check_val("vs_low_width", vs_low, 32);
      check_val("vs_first_low", vs_first, 98);
      check_val("vs_contiguous", vs_last - vs_first + 1, 32);
      check_val("frame_count_inc", fc[2], 8'((fc0 + 1) % 256));

      // asynchronous reset mid-hsync and mid-vsync
      for (int n = 0; n < 200 && !(mdl[2].x == 12 && mdl[2].y == 7); n++) tick(1'b1);
      check_val("pre_rst_pos", {xp[2], yp[2]}, {10'd12, 10'd7});
      check_val("pre_rst_hsync", hs[2], 1'b0);
      check_val("pre_rst_vsync", vs[2], 1'b0);
      #3 rst_n = 1'b0;
      for (int i = 0; i < 3; i++) mdl[i] = m_reset();
      push_expected();
      #1 pop_compare();
      check_val("async_rst_hsync", hs[2], 1'b1);
      check_val("async_rst_vsync", vs[2], 1'b1);
      check_val("async_rst_pos", {xp[2], yp[2]}, 20'd0);
      check_val("async_rst_fc", fc[2], 8'd0);
      @(negedge clk25);
      tick(1'b1);
      tick(1'b1);

      // 256 reduced frames: frame counter wraps
      rst_n = 1'b1;
      for (int k = 1; k <= 256 * 160; k++) begin
         tick(1'b1);
         if (k == 159) check_val("fc_before_wrap_edge", fc[2], 8'd0);
         if (k == 160) check_val("fc_first_frame", {xp[2], yp[2], fc[2]}, {10'd0, 10'd0, 8'd1});
         if (k == 255 * 160) check_val("fc_255", fc[2], 8'd255);
      end
      check_val("fc_wrap", {xp[2], yp[2], fc[2]}, 28'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
